fc8_system: RTL and testbench
=============================

FC8_SYSTEM -- requirements
Module: fc8_system

Interface
REQ-001 The block SHALL have no parameters; shared constants SHALL come from fc8_defines.v: PAGE_SELECT_REG_ADDR = 16'h00FF; N_FLAG_BIT = 7; V_FLAG_BIT = 6; B_FLAG_BIT = 4; D_FLAG_BIT = 3; I_FLAG_BIT = 2; Z_FLAG_BIT = 1; C_FLAG_BIT = 0.
REQ-002 The block SHALL have one clock, master_clk (input, 1 bit); all state SHALL update on its rising edge.
REQ-003 The block SHALL have master_rst_n (input, 1 bit), a synchronous, active-low reset.
REQ-004 The block SHALL have no other ports.
REQ-005 The block SHALL expose the following instances, signals and internal registers under exactly these hierarchical names for bench probing:
- u_cpu: pc[15:0], opcode[7:0], a, x, y (8-bit each), sp[15:0], f[7:0]
- u_fixed_ram: mem[0:32767] (8-bit)
- u_mmu: page_select_reg_internal[7:0]
- u_sfr_block: palette_addr_reg[7:0], palette_ram[0:255] (8-bit)
- top-level wires: mmu_sfr_addr_out[15:0], mmu_sfr_data_to_sfr_block[7:0], sfr_block_data_to_mmu[7:0], mmu_sfr_wr_en_out, mmu_sfr_cs_out

Function
REQ-006 Memory map SHALL be:
- $0000-$7FFF: fixed RAM, read/write
- $8000-$BFFF: paged window, unpopulated; reads return $FF, writes ignored
- $C000-$C0FF: SFR block
- $C100-$EFFF: unmapped; reads return $FF
- $F000-$FFFF: program ROM, read-only
REQ-007 Memory reads SHALL be combinational within the cycle; writes SHALL commit on the clock edge ending the write cycle.
REQ-008 u_mmu SHALL decode SFR accesses as follows:
- mmu_sfr_cs_out = 1 for any access in $C000-$C0FF
- mmu_sfr_addr_out = {8'h00, addr[7:0]}
- mmu_sfr_data_to_sfr_block = CPU write data
- mmu_sfr_wr_en_out = cs AND CPU write
REQ-009 Any CPU write to PAGE_SELECT_REG_ADDR SHALL update both u_fixed_ram.mem[$00FF] and page_select_reg_internal in the same edge.
REQ-010 The SFR register map (offset: behaviour) SHALL be:
- $00 VRAM_SCROLL_X_REG: read/write
- $01 INPUT_STATUS_REG: read-only; value $01 (gamepad 1 connected)
- $02 INT_STATUS_REG: read; writing 1 to a bit clears that bit (write-1-to-clear); no set sources
- $03 PALETTE_ADDR_REG: write-only; reads $00
- $04 PALETTE_DATA_REG: write stores palette_ram[palette_addr_reg] and increments palette_addr_reg modulo 256 ($FF wraps to $00); reads return palette_ram[palette_addr_reg] with no increment
- all other offsets: read $00, writes ignored
REQ-011 u_cpu SHALL be a multicycle 6502-subset CPU, one bus access per cycle, executing:
- LDA #imm ($A9): 2 cycles; updates N and Z
- LDA abs ($AD): 4 cycles; updates N and Z
- STA abs ($8D): 4 cycles; no flag change
- JMP abs ($4C): 3 cycles
- any other opcode: 1-cycle NOP
Absolute operands SHALL be little-endian. opcode SHALL hold the most recently fetched opcode byte.
REQ-012 CPU flag rules: f[5] SHALL always read 1; N = bit 7 of the loaded value; Z = 1 when the loaded value is zero; all other flags unchanged.
REQ-013 The ROM SHALL hold the following program at $F000, in order:
- LDA #$04; STA $00FF
- LDA #$A5; STA $C000; LDA $C000; STA $0000
- LDA $C001; STA $0001
- LDA $C002; STA $0002; LDA #$01; STA $C002; LDA $C002; STA $0003
- LDA #$10; STA $C003; LDA #$E0; STA $C004; LDA #$C3; STA $C004
- JMP to its own address (halt loop)
The program SHALL complete in under 600 cycles after reset release.

Reset
REQ-014 While master_rst_n = 0 at a rising edge, the CPU SHALL load: pc = $F000, opcode = $00, a = x = y = 0, sp = $01FF, f = $24, and return to the fetch state.
REQ-015 The same reset SHALL load: page_select_reg_internal = $00; VRAM_SCROLL_X_REG = $00; INT_STATUS_REG = $03; palette_addr_reg = $00.
REQ-016 Reset SHALL NOT alter fixed RAM or palette_ram contents; at simulation start both SHALL initialise to $00.
REQ-017 Reset asserted mid-instruction SHALL abort the instruction with no pending write; execution SHALL restart from $F000 on release.

Verification
REQ-018 Reset for 2 cycles, run 3000 ns -> mem[$00FF] = $04 and page_select_reg_internal = $04.
REQ-019 Same run -> mem[$0000] = $A5 (scroll register readback); mem[$0001] = $01 (input status).
REQ-020 Same run -> mem[$0002] = $03; mem[$0003] = $02 (write-1-to-clear of bit 0).
REQ-021 Same run -> palette_addr_reg = $12; palette_ram[$10] = $E0; palette_ram[$11] = $C3; pc stuck at the JMP address.
REQ-022 During STA $C000 -> mmu_sfr_cs_out = 1, mmu_sfr_wr_en_out = 1, mmu_sfr_addr_out = $0000, mmu_sfr_data_to_sfr_block = $A5 for exactly one cycle.
REQ-023 Assert reset during the STA $C002 sequence, then release -> registers return to their REQ-014/REQ-015 values and the final results still match REQ-018 to REQ-021.

Source files
------------

// File: rtl/fc8_system.sv
// FC8 system: 6502-subset multicycle CPU, MMU, 32 KiB fixed RAM,
// SFR block (scroll, input status, interrupt status, palette) and program ROM.
//
// Bus handshake (CPU <-> MMU): there is no valid/ready pair. The CPU presents
// exactly one access per cycle. bus_addr is always valid. bus_we marks a
// write that every target commits on the rising edge ending the cycle.
// Read data returns combinationally in the same cycle.

package fc8_defines;
  localparam logic [15:0] PAGE_SELECT_REG_ADDR = 16'h00FF;
  localparam int N_FLAG_BIT = 7;
  localparam int V_FLAG_BIT = 6;
  localparam int B_FLAG_BIT = 4;
  localparam int D_FLAG_BIT = 3;
  localparam int I_FLAG_BIT = 2;
  localparam int Z_FLAG_BIT = 1;
  localparam int C_FLAG_BIT = 0;
endpackage

// ---------------------------------------------------------------------------
// Multicycle CPU: FETCH -> OPLO -> OPHI -> EXEC, one bus access per state.
// ---------------------------------------------------------------------------
module fc8_cpu
  import fc8_defines::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [15:0] bus_addr_o,
  output logic [7:0]  bus_wdata_o,
  output logic        bus_we_o,
  input  logic [7:0]  bus_rdata_i,
  output logic [1:0]  state_dbg_o
);
  typedef enum logic [1:0] {S_FETCH, S_OPLO, S_OPHI, S_EXEC} state_e;

  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_LDA_ABS = 8'hAD;
  localparam logic [7:0] OP_STA_ABS = 8'h8D;
  localparam logic [7:0] OP_JMP_ABS = 8'h4C;

  state_e      state_q;
  logic [15:0] pc;
  logic [7:0]  opcode;
  logic [7:0]  a;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [15:0] sp;
  logic [7:0]  f;
  logic [7:0]  oplo_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        we_q;

  // Load-result flag update: N and Z follow the value, bit 5 is hard-wired 1.
  function automatic logic [7:0] ld_flags(input logic [7:0] f_in, input logic [7:0] v);
    logic [7:0] r;
    r             = f_in;
    r[N_FLAG_BIT] = v[7];
    r[Z_FLAG_BIT] = (v == 8'h00);
    r[5]          = 1'b1;
    return r;
  endfunction

  function automatic logic is_known_op(input logic [7:0] op);
    return (op == OP_LDA_IMM) || (op == OP_LDA_ABS) ||
           (op == OP_STA_ABS) || (op == OP_JMP_ABS);
  endfunction

  // The write strobe is masked by reset so an aborted STA never commits.
  assign bus_we_o    = we_q & rst_ni;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign state_dbg_o = state_q;

  // Instruction sequencer; the bus address for the next cycle is registered here.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_FETCH;
      pc      <= 16'hF000;
      opcode  <= 8'h00;
      a       <= 8'h00;
      x       <= 8'h00;
      y       <= 8'h00;
      sp      <= 16'h01FF;
      f       <= 8'h24;
      oplo_q  <= 8'h00;
      addr_q  <= 16'hF000;
      wdata_q <= 8'h00;
      we_q    <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          opcode  <= bus_rdata_i;
          pc      <= pc + 16'd1;
          addr_q  <= pc + 16'd1;
          state_q <= is_known_op(bus_rdata_i) ? S_OPLO : S_FETCH;
        end
        S_OPLO: begin
          oplo_q <= bus_rdata_i;
          pc     <= pc + 16'd1;
          addr_q <= pc + 16'd1;
          if (opcode == OP_LDA_IMM) begin
            a       <= bus_rdata_i;
            f       <= ld_flags(f, bus_rdata_i);
            state_q <= S_FETCH;
          end else begin
            state_q <= S_OPHI;
          end
        end
        S_OPHI: begin
          if (opcode == OP_JMP_ABS) begin
            pc      <= {bus_rdata_i, oplo_q};
            addr_q  <= {bus_rdata_i, oplo_q};
            state_q <= S_FETCH;
          end else begin
            pc      <= pc + 16'd1;
            addr_q  <= {bus_rdata_i, oplo_q};
            we_q    <= (opcode == OP_STA_ABS);
            wdata_q <= a;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (opcode == OP_LDA_ABS) begin
            a <= bus_rdata_i;
            f <= ld_flags(f, bus_rdata_i);
          end
          we_q    <= 1'b0;
          addr_q  <= pc;
          state_q <= S_FETCH;
        end
        default: begin
          we_q    <= 1'b0;
          addr_q  <= pc;
          state_q <= S_FETCH;
        end
      endcase
    end
  end
endmodule

// ---------------------------------------------------------------------------
// 32 KiB fixed RAM, combinational read, write on clock edge. Never reset.
// ---------------------------------------------------------------------------
module fc8_fixed_ram (
  input  logic        clk_i,
  input  logic [14:0] addr_i,
  input  logic [7:0]  wdata_i,
  input  logic        we_i,
  output logic [7:0]  rdata_o
);
  logic [7:0] mem [0:32767] = '{default: 8'h00};

  assign rdata_o = mem[addr_i];

  // Byte write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end
endmodule

// ---------------------------------------------------------------------------
// Program ROM at $F000-$FFFF; unprogrammed bytes decode as NOPs.
// ---------------------------------------------------------------------------
module fc8_rom (
  input  logic [11:0] addr_i,
  output logic [7:0]  data_o
);
  // Boot program ending in a self-jump at $F036.
  always_comb begin
    data_o = 8'h00;
    case (addr_i)
      12'h000: data_o = 8'hA9; 12'h001: data_o = 8'h04;                          // LDA #$04
      12'h002: data_o = 8'h8D; 12'h003: data_o = 8'hFF; 12'h004: data_o = 8'h00; // STA $00FF
      12'h005: data_o = 8'hA9; 12'h006: data_o = 8'hA5;                          // LDA #$A5
      12'h007: data_o = 8'h8D; 12'h008: data_o = 8'h00; 12'h009: data_o = 8'hC0; // STA $C000
      12'h00A: data_o = 8'hAD; 12'h00B: data_o = 8'h00; 12'h00C: data_o = 8'hC0; // LDA $C000
      12'h00D: data_o = 8'h8D; 12'h00E: data_o = 8'h00; 12'h00F: data_o = 8'h00; // STA $0000
      12'h010: data_o = 8'hAD; 12'h011: data_o = 8'h01; 12'h012: data_o = 8'hC0; // LDA $C001
      12'h013: data_o = 8'h8D; 12'h014: data_o = 8'h01; 12'h015: data_o = 8'h00; // STA $0001
      12'h016: data_o = 8'hAD; 12'h017: data_o = 8'h02; 12'h018: data_o = 8'hC0; // LDA $C002
      12'h019: data_o = 8'h8D; 12'h01A: data_o = 8'h02; 12'h01B: data_o = 8'h00; // STA $0002
      12'h01C: data_o = 8'hA9; 12'h01D: data_o = 8'h01;                          // LDA #$01
      12'h01E: data_o = 8'h8D; 12'h01F: data_o = 8'h02; 12'h020: data_o = 8'hC0; // STA $C002
      12'h021: data_o = 8'hAD; 12'h022: data_o = 8'h02; 12'h023: data_o = 8'hC0; // LDA $C002
      12'h024: data_o = 8'h8D; 12'h025: data_o = 8'h03; 12'h026: data_o = 8'h00; // STA $0003
      12'h027: data_o = 8'hA9; 12'h028: data_o = 8'h10;                          // LDA #$10
      12'h029: data_o = 8'h8D; 12'h02A: data_o = 8'h03; 12'h02B: data_o = 8'hC0; // STA $C003
      12'h02C: data_o = 8'hA9; 12'h02D: data_o = 8'hE0;                          // LDA #$E0
      12'h02E: data_o = 8'h8D; 12'h02F: data_o = 8'h04; 12'h030: data_o = 8'hC0; // STA $C004
      12'h031: data_o = 8'hA9; 12'h032: data_o = 8'hC3;                          // LDA #$C3
      12'h033: data_o = 8'h8D; 12'h034: data_o = 8'h04; 12'h035: data_o = 8'hC0; // STA $C004
      12'h036: data_o = 8'h4C; 12'h037: data_o = 8'h36; 12'h038: data_o = 8'hF0; // JMP $F036
      default: data_o = 8'h00;
    endcase
  end
endmodule

// ---------------------------------------------------------------------------
// MMU: address decode, read mux and page-select shadow register.
// ---------------------------------------------------------------------------
module fc8_mmu
  import fc8_defines::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_wdata_i,
  input  logic        cpu_we_i,
  output logic [7:0]  cpu_rdata_o,
  output logic [14:0] ram_addr_o,
  output logic [7:0]  ram_wdata_o,
  output logic        ram_we_o,
  input  logic [7:0]  ram_rdata_i,
  output logic [15:0] sfr_addr_o,
  output logic [7:0]  sfr_wdata_o,
  output logic        sfr_wr_en_o,
  output logic        sfr_cs_o,
  input  logic [7:0]  sfr_rdata_i,
  output logic [11:0] rom_addr_o,
  input  logic [7:0]  rom_data_i
);
  logic [7:0] page_select_reg_internal;
  logic       ram_sel;
  logic       rom_sel;

  assign ram_sel     = ~cpu_addr_i[15];
  assign rom_sel     = (cpu_addr_i[15:12] == 4'hF);
  assign sfr_cs_o    = (cpu_addr_i[15:8] == 8'hC0);
  assign sfr_addr_o  = {8'h00, cpu_addr_i[7:0]};
  assign sfr_wdata_o = cpu_wdata_i;
  assign sfr_wr_en_o = sfr_cs_o & cpu_we_i;
  assign ram_addr_o  = cpu_addr_i[14:0];
  assign ram_wdata_o = cpu_wdata_i;
  assign ram_we_o    = ram_sel & cpu_we_i;
  assign rom_addr_o  = cpu_addr_i[11:0];

  // Read mux; the paged window and unmapped space float high.
  always_comb begin
    cpu_rdata_o = 8'hFF;
    if (ram_sel) begin
      cpu_rdata_o = ram_rdata_i;
    end else if (sfr_cs_o) begin
      cpu_rdata_o = sfr_rdata_i;
    end else if (rom_sel) begin
      cpu_rdata_o = rom_data_i;
    end
  end

  // Page select shadows the RAM byte at $00FF, written in the same edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      page_select_reg_internal <= 8'h00;
    end else if (cpu_we_i && (cpu_addr_i == PAGE_SELECT_REG_ADDR)) begin
      page_select_reg_internal <= cpu_wdata_i;
    end
  end
endmodule

// ---------------------------------------------------------------------------
// SFR block: scroll, input status, W1C interrupt status, palette port.
// ---------------------------------------------------------------------------
module fc8_sfr_block (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  input  logic       wr_en_i,
  input  logic       cs_i,
  output logic [7:0] rdata_o
);
  localparam logic [7:0] SFR_SCROLL_X   = 8'h00;
  localparam logic [7:0] SFR_INPUT_STAT = 8'h01;
  localparam logic [7:0] SFR_INT_STAT   = 8'h02;
  localparam logic [7:0] SFR_PAL_ADDR   = 8'h03;
  localparam logic [7:0] SFR_PAL_DATA   = 8'h04;

  logic [7:0] vram_scroll_x_reg;
  logic [7:0] int_status_reg;
  logic [7:0] palette_addr_reg;
  logic [7:0] palette_ram [0:255] = '{default: 8'h00};

  // Register read mux; palette data reads have no side effect.
  always_comb begin
    rdata_o = 8'h00;
    if (cs_i) begin
      case (addr_i)
        SFR_SCROLL_X:   rdata_o = vram_scroll_x_reg;
        SFR_INPUT_STAT: rdata_o = 8'h01;
        SFR_INT_STAT:   rdata_o = int_status_reg;
        SFR_PAL_DATA:   rdata_o = palette_ram[palette_addr_reg];
        default:        rdata_o = 8'h00;
      endcase
    end
  end

  // Control registers; palette address auto-increments after each data write.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vram_scroll_x_reg <= 8'h00;
      int_status_reg    <= 8'h03;
      palette_addr_reg  <= 8'h00;
    end else if (wr_en_i) begin
      case (addr_i)
        SFR_SCROLL_X: vram_scroll_x_reg <= wdata_i;
        SFR_INT_STAT: int_status_reg    <= int_status_reg & ~wdata_i;
        SFR_PAL_ADDR: palette_addr_reg  <= wdata_i;
        SFR_PAL_DATA: palette_addr_reg  <= palette_addr_reg + 8'd1;
        default: ;
      endcase
    end
  end

  // Palette storage keeps its contents across reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && (addr_i == SFR_PAL_DATA)) begin
      palette_ram[palette_addr_reg] <= wdata_i;
    end
  end
endmodule

// ---------------------------------------------------------------------------
// Top level.
// ---------------------------------------------------------------------------
module fc8_system (
  input logic master_clk,
  input logic master_rst_n
);
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic [7:0]  cpu_rdata;
  logic [1:0]  cpu_state_dbg;
  logic [14:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic [15:0] mmu_sfr_addr_out;
  logic [7:0]  mmu_sfr_data_to_sfr_block;
  logic [7:0]  sfr_block_data_to_mmu;
  logic        mmu_sfr_wr_en_out;
  logic        mmu_sfr_cs_out;

  fc8_cpu u_cpu (
    .clk_i       (master_clk),
    .rst_ni      (master_rst_n),
    .bus_addr_o  (cpu_addr),
    .bus_wdata_o (cpu_wdata),
    .bus_we_o    (cpu_we),
    .bus_rdata_i (cpu_rdata),
    .state_dbg_o (cpu_state_dbg)
  );

  fc8_mmu u_mmu (
    .clk_i       (master_clk),
    .rst_ni      (master_rst_n),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_we_i    (cpu_we),
    .cpu_rdata_o (cpu_rdata),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_we_o    (ram_we),
    .ram_rdata_i (ram_rdata),
    .sfr_addr_o  (mmu_sfr_addr_out),
    .sfr_wdata_o (mmu_sfr_data_to_sfr_block),
    .sfr_wr_en_o (mmu_sfr_wr_en_out),
    .sfr_cs_o    (mmu_sfr_cs_out),
    .sfr_rdata_i (sfr_block_data_to_mmu),
    .rom_addr_o  (rom_addr),
    .rom_data_i  (rom_data)
  );

  fc8_fixed_ram u_fixed_ram (
    .clk_i   (master_clk),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .we_i    (ram_we),
    .rdata_o (ram_rdata)
  );

  fc8_sfr_block u_sfr_block (
    .clk_i   (master_clk),
    .rst_ni  (master_rst_n),
    .addr_i  (mmu_sfr_addr_out[7:0]),
    .wdata_i (mmu_sfr_data_to_sfr_block),
    .wr_en_i (mmu_sfr_wr_en_out),
    .cs_i    (mmu_sfr_cs_out),
    .rdata_o (sfr_block_data_to_mmu)
  );

  fc8_rom u_rom (
    .addr_i (rom_addr),
    .data_o (rom_data)
  );
endmodule

// File: tb/tb_fc8_system.sv
// Directed bench for fc8_system: boot program results, SFR write strobe,
// and reset aborting the STA $C002 instruction.
module tb_fc8_system;
  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  int scroll_wr_cnt  = 0;
  int scroll_wr_bad  = 0;
  int wr_no_cs_cnt   = 0;

  fc8_system dut (
    .master_clk   (clk),
    .master_rst_n (rst_n)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hold reset for two rising edges; leaves the bench at a falling edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string pfx);
    check_eq({pfx, " pc"},       dut.u_cpu.pc,     32'hF000);
    check_eq({pfx, " opcode"},   dut.u_cpu.opcode, 32'h00);
    check_eq({pfx, " a"},        dut.u_cpu.a,      32'h00);
    check_eq({pfx, " x"},        dut.u_cpu.x,      32'h00);
    check_eq({pfx, " y"},        dut.u_cpu.y,      32'h00);
    check_eq({pfx, " sp"},       dut.u_cpu.sp,     32'h01FF);
    check_eq({pfx, " f"},        dut.u_cpu.f,      32'h24);
    check_eq({pfx, " page_sel"}, dut.u_mmu.page_select_reg_internal, 32'h00);
    check_eq({pfx, " scroll"},   dut.u_sfr_block.vram_scroll_x_reg,  32'h00);
    check_eq({pfx, " int_stat"}, dut.u_sfr_block.int_status_reg,     32'h03);
    check_eq({pfx, " pal_addr"}, dut.u_sfr_block.palette_addr_reg,   32'h00);
    check_eq({pfx, " sfr_wr"},   dut.mmu_sfr_wr_en_out,              32'h0);
  endtask

  // Wait (sampling on falling edges) until pc equals target, within budget cycles.
  task automatic wait_pc(input logic [15:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dut.u_cpu.pc == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Scoreboard for the scroll-register write strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dut.mmu_sfr_wr_en_out && !dut.mmu_sfr_cs_out)
        wr_no_cs_cnt++;
      if (dut.mmu_sfr_cs_out && dut.mmu_sfr_wr_en_out && dut.mmu_sfr_addr_out == 16'h0000) begin
        scroll_wr_cnt++;
        if (dut.mmu_sfr_data_to_sfr_block !== 8'hA5)
          scroll_wr_bad++;
      end
    end
  end

  initial begin
    bit ok;
    logic [15:0] pc_min;
    logic [15:0] pc_max;

    // Phase 1: power-on reset, run into the STA $C002 instruction.
    apply_reset();
    check_reset_state("por");
    rst_n = 1'b1;

    wait_pc(16'hF020, 600, ok);
    check_eq("reach_sta_c002", ok, 1);
    check_eq("mid ram00ff",   dut.u_fixed_ram.mem[16'h00FF], 32'h04);
    check_eq("mid page_sel",  dut.u_mmu.page_select_reg_internal, 32'h04);
    check_eq("mid ram0000",   dut.u_fixed_ram.mem[0], 32'hA5);
    check_eq("mid ram0001",   dut.u_fixed_ram.mem[1], 32'h01);
    check_eq("mid ram0002",   dut.u_fixed_ram.mem[2], 32'h03);
    check_eq("mid int_stat",  dut.u_sfr_block.int_status_reg, 32'h03);
    check_eq("mid a",         dut.u_cpu.a, 32'h01);
    check_eq("mid opcode",    dut.u_cpu.opcode, 32'h8D);
    check_eq("scroll_wr_cnt1", scroll_wr_cnt, 1);

    // Abort the STA $C002 before its write cycle.
    apply_reset();
    check_reset_state("abort");
    check_eq("abort int_stat_kept", dut.u_sfr_block.int_status_reg, 32'h03);
    check_eq("abort ram0003", dut.u_fixed_ram.mem[3], 32'h00);
    rst_n = 1'b1;

    // Phase 2: full program run from $F000.
    wait_pc(16'hF037, 600, ok);
    check_eq("reach_halt", ok, 1);
    repeat (300) @(negedge clk);

    check_eq("ram00ff",   dut.u_fixed_ram.mem[16'h00FF], 32'h04);
    check_eq("page_sel",  dut.u_mmu.page_select_reg_internal, 32'h04);
    check_eq("ram0000",   dut.u_fixed_ram.mem[0], 32'hA5);
    check_eq("ram0001",   dut.u_fixed_ram.mem[1], 32'h01);
    check_eq("ram0002",   dut.u_fixed_ram.mem[2], 32'h03);
    check_eq("ram0003",   dut.u_fixed_ram.mem[3], 32'h02);
    check_eq("int_stat",  dut.u_sfr_block.int_status_reg, 32'h02);
    check_eq("scroll",    dut.u_sfr_block.vram_scroll_x_reg, 32'hA5);
    check_eq("pal_addr",  dut.u_sfr_block.palette_addr_reg, 32'h12);
    check_eq("pal10",     dut.u_sfr_block.palette_ram[8'h10], 32'hE0);
    check_eq("pal11",     dut.u_sfr_block.palette_ram[8'h11], 32'hC3);
    check_eq("pal0f",     dut.u_sfr_block.palette_ram[8'h0F], 32'h00);
    check_eq("final a",   dut.u_cpu.a, 32'hC3);
    check_eq("final f",   dut.u_cpu.f, 32'hA4);
    check_eq("opcode_jmp", dut.u_cpu.opcode, 32'h4C);

    // Halt loop: pc only ever cycles through the three JMP bytes.
    pc_min = 16'hFFFF;
    pc_max = 16'h0000;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (dut.u_cpu.pc < pc_min) pc_min = dut.u_cpu.pc;
      if (dut.u_cpu.pc > pc_max) pc_max = dut.u_cpu.pc;
    end
    check_eq("halt pc_min", pc_min, 32'hF036);
    check_eq("halt pc_max", pc_max, 32'hF038);

    // One single-cycle $A5 strobe to SFR offset 0 per program run.
    check_eq("scroll_wr_cnt2", scroll_wr_cnt, 2);
    check_eq("scroll_wr_data", scroll_wr_bad, 0);
    check_eq("wr_without_cs",  wr_no_cs_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
